fetch_control: RTL and testbench



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_control_branch_resolver.sv | 36 +++
 rtl/fetch_control.sv | 121 ++++++++++++
 tb/tb_fetch_control.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode constants, state and branch-condition encodings
// for the fetch control stage.
package fetch_pkg;

    localparam logic [3:0] OP_JMP  = 4'hF;
    localparam logic [3:0] OP_BR   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hD;

    typedef enum logic [1:0] {
        START    = 2'd0,
        FETCH    = 2'd1,
        DISPATCH = 2'd2,
        HALTED   = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        ALWAYS = 2'd0,
        IF_Z   = 2'd1,
        IF_NZ  = 2'd2,
        IF_NEG = 2'd3
    } br_cond_t;

    function automatic logic [3:0] opcode(input logic [15:0] ins);
        return ins[15:12];
    endfunction

endpackage

// File: rtl/fetch_control_branch_resolver.sv
// Combinational jump/branch decode: jump target within the current
// 4K page and the condition outcome for relative branches.
module branch_resolver
    import fetch_pkg::*;
(
    input  logic [15:0] ir_i,
    input  logic [15:0] pc_i,
    input  logic        zero_i,
    input  logic        negative_i,
    output logic        is_jmp_o,
    output logic        take_branch_o,
    output logic [15:0] target_o,
    output logic [8:0]  offset_o
);

    br_cond_t cond;
    logic     cond_true;

    assign cond = br_cond_t'(ir_i[10:9]);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            ALWAYS: cond_true = 1'b1;
            IF_Z:   cond_true = zero_i;
            IF_NZ:  cond_true = ~zero_i;
            IF_NEG: cond_true = negative_i;
        endcase
    end

    assign is_jmp_o      = (opcode(ir_i) == OP_JMP);
    assign take_branch_o = (opcode(ir_i) == OP_BR) && cond_true;
    assign target_o      = {pc_i[15:12], ir_i[11:0]};
    assign offset_o      = ir_i[8:0];

endmodule

// File: rtl/fetch_control.sv
// Fetch control stage: fetches one instruction per PC, hands it to
// the decoder and steers the free-running program counter.
module fetch_control
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] CounterValue,
    output logic [15:0] LoadValue,
    output logic        LoadEnable,
    output logic [8:0]  Offset,
    output logic        OffsetEnable,
    output logic [15:0] InstrAddress,
    output logic        InstrReq,
    input  logic        InstrValid,
    input  logic [15:0] InstrData,
    output logic [15:0] OutInstr,
    output logic        OutValid,
    input  logic        OutReady,
    input  logic        Zero,
    input  logic        Negative,
    output logic        Halted,
    output logic        FetchError
);

    localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

    fetch_state_t state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic [7:0]   wait_q, wait_d;
    logic         ferr_q, ferr_d;

    logic        is_jmp;
    logic        take_br;
    logic [15:0] target;
    logic [8:0]  br_off;
    logic        handshake;

    branch_resolver u_branch_resolver (
        .ir_i         (ir_q),
        .pc_i         (CounterValue),
        .zero_i       (Zero),
        .negative_i   (Negative),
        .is_jmp_o     (is_jmp),
        .take_branch_o(take_br),
        .target_o     (target),
        .offset_o     (br_off)
    );

    assign handshake = (state_q == DISPATCH) && OutReady;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                if (InstrValid) begin
                    ir_d    = InstrData;
                    wait_d  = 8'd0;
                    state_d = (opcode(InstrData) == OP_HALT)
                            ? HALTED : DISPATCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TIMEOUT) begin
                        ferr_d  = 1'b1;
                        state_d = HALTED;
                    end
                end
            end
            DISPATCH: begin
                if (OutReady) state_d = FETCH;
            end
            HALTED: state_d = HALTED;
        endcase
    end

    // Counter advances by one unless held, so idle cycles assert offset 0.
    always_comb begin
        LoadEnable   = 1'b0;
        LoadValue    = 16'd0;
        OffsetEnable = 1'b1;
        Offset       = 9'd0;
        if (handshake) begin
            OffsetEnable = 1'b0;
            if (is_jmp) begin
                LoadEnable = 1'b1;
                LoadValue  = target;
            end else if (take_br) begin
                OffsetEnable = 1'b1;
                Offset       = br_off;
            end
        end
    end

    assign InstrReq     = (state_q == FETCH);
    assign InstrAddress = CounterValue;
    assign OutValid     = (state_q == DISPATCH);
    assign OutInstr     = ir_q;
    assign Halted       = (state_q == HALTED);
    assign FetchError   = ferr_q;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= START;
            ir_q    <= 16'd0;
            wait_q  <= 8'd0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: PC counter and memory models, directed
// scenarios, then a random program checked at transaction level.
module tb_fetch_control;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] CounterValue;
    logic [15:0] LoadValue;
    logic        LoadEnable;
    logic [8:0]  Offset;
    logic        OffsetEnable;
    logic [15:0] InstrAddress;
    logic        InstrReq;
    logic        InstrValid = 1'b0;
    logic [15:0] InstrData = 16'd0;
    logic [15:0] OutInstr;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic        Zero = 1'b0;
    logic        Negative = 1'b0;
    logic        Halted;
    logic        FetchError;

    int errors = 0;
    int checks = 0;

    logic [15:0] pc = 16'd0;
    logic        force_pc = 1'b0;
    logic [15:0] force_val = 16'd0;
    int          lat_cfg = 0;
    bit          lat_rand = 1'b0;
    int          ready_mode = 1;
    bit          flag_rand = 1'b0;
    logic        zero_fix = 1'b0;
    bit          mon_en = 1'b0;
    int          wait_cnt = 0;
    int          hs_count = 0;
    logic [15:0] mem [logic [15:0]];

    logic [15:0] fetched = 16'd0;
    logic [15:0] exp_addr = 16'd0;
    logic [15:0] prev_instr = 16'd0;
    logic [15:0] prev_pc = 16'd0;
    bit          pending = 1'b0;
    bit          prev_stall = 1'b0;

    assign CounterValue = pc;

    always #5 Clock = ~Clock;

    fetch_control #(.FETCH_TIMEOUT(15)) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .CounterValue(CounterValue),
        .LoadValue   (LoadValue),
        .LoadEnable  (LoadEnable),
        .Offset      (Offset),
        .OffsetEnable(OffsetEnable),
        .InstrAddress(InstrAddress),
        .InstrReq    (InstrReq),
        .InstrValid  (InstrValid),
        .InstrData   (InstrData),
        .OutInstr    (OutInstr),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .Zero        (Zero),
        .Negative    (Negative),
        .Halted      (Halted),
        .FetchError  (FetchError)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       r[15:12] = 4'hF;
            1:       r[15:12] = 4'hE;
            default: r[15:12] = 4'($urandom_range(0, 12));
        endcase
        return r;
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] p,
                                            input logic [15:0] ins,
                                            input logic z,
                                            input logic n);
        logic take;
        case (ins[10:9])
            2'd0:    take = 1'b1;
            2'd1:    take = z;
            2'd2:    take = !z;
            default: take = n;
        endcase
        if (ins[15:12] == 4'hF) return {p[15:12], ins[11:0]};
        if (ins[15:12] == 4'hE && take) return p + 16'($signed(ins[8:0]));
        return p + 16'd1;
    endfunction

    // Program counter: increments unless loaded or offset.
    always @(posedge Clock) begin
        if (force_pc) pc <= force_val;
        else if (LoadEnable) pc <= LoadValue;
        else if (OffsetEnable) pc <= pc + 16'($signed(Offset));
        else pc <= pc + 16'd1;
    end

    always @(negedge Clock) begin
        InstrValid = 1'b0;
        if (InstrReq && lat_cfg >= 0) begin
            if (wait_cnt >= lat_cfg) begin
                if (!mem.exists(InstrAddress)) mem[InstrAddress] = rand_instr();
                InstrData  = mem[InstrAddress];
                InstrValid = 1'b1;
                wait_cnt   = 0;
                if (lat_rand) lat_cfg = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        case (ready_mode)
            0:       OutReady = 1'b0;
            1:       OutReady = 1'b1;
            default: OutReady = ($urandom_range(0, 2) != 0);
        endcase
        if (flag_rand) begin
            Zero     = 1'($urandom_range(0, 1));
            Negative = 1'($urandom_range(0, 1));
        end else begin
            Zero     = zero_fix;
            Negative = 1'b0;
        end
        #1;
        if (!mon_en) begin
            pending    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(OutValid), 32'd1);
                check("stall_instr", 32'(OutInstr), 32'(prev_instr));
                check("stall_pc", 32'(CounterValue), 32'(prev_pc));
            end
            if (InstrReq && pending) begin
                check("next_addr", 32'(InstrAddress), 32'(exp_addr));
                pending = 1'b0;
            end
            if (InstrReq && InstrValid) fetched = InstrData;
            if (OutValid && OutReady) begin
                hs_count++;
                check("hs_instr", 32'(OutInstr), 32'(fetched));
                check("hs_strobes", 32'(LoadEnable & OffsetEnable), 32'd0);
                exp_addr = next_pc(CounterValue, fetched, Zero, Negative);
                pending  = 1'b1;
            end
            prev_stall = OutValid && !OutReady;
            prev_instr = OutInstr;
            prev_pc    = CounterValue;
        end
    end

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] start_pc);
        nReset    = 1'b0;
        force_pc  = 1'b1;
        force_val = start_pc;
        step();
        step();
        nReset   = 1'b1;
        force_pc = 1'b0;
    endtask

    initial begin
        // Sequential fetch after reset
        mem[16'h0010] = 16'h1234;
        do_reset(16'h0010);
        check("rst_req", 32'(InstrReq), 32'd0);
        check("rst_valid", 32'(OutValid), 32'd0);
        check("rst_strobes", {LoadEnable, OffsetEnable, Halted, FetchError},
              32'b0100);
        check("rst_off", {Offset, LoadValue}, 32'd0);
        step();
        check("first_req", 32'(InstrReq), 32'd1);
        check("first_addr", 32'(InstrAddress), 32'h0010);
        step();
        check("disp_instr", {OutValid, OutInstr}, 32'h11234);
        check("disp_norm", {LoadEnable, OffsetEnable}, 32'b00);
        step();
        check("seq_addr", 32'(InstrAddress), 32'h0011);

        mem[16'h2005] = 16'hF0AB;
        do_reset(16'h2005);
        step();
        step();
        check("jmp_strobe", {LoadEnable, OffsetEnable}, 32'b10);
        check("jmp_value", 32'(LoadValue), 32'h20AB);
        step();
        check("jmp_once", 32'(LoadEnable), 32'd0);
        check("jmp_addr", 32'(InstrAddress), 32'h20AB);

        mem[16'h0100] = 16'hE3FC;
        zero_fix = 1'b1;
        do_reset(16'h0100);
        step();
        step();
        check("br_t_strobe", {LoadEnable, OffsetEnable}, 32'b01);
        check("br_t_off", 32'(Offset), 32'h1FC);
        step();
        check("br_t_addr", 32'(InstrAddress), 32'h00FC);
        zero_fix = 1'b0;
        do_reset(16'h0100);
        step();
        step();
        check("br_nt_strobe", {LoadEnable, OffsetEnable}, 32'b00);
        step();
        check("br_nt_addr", 32'(InstrAddress), 32'h0101);

        // Decoder back-pressure
        mem[16'h0300] = 16'h1111;
        ready_mode = 0;
        do_reset(16'h0300);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_out", {OutValid, OutInstr}, 32'h11111);
            check("bp_hold", {OffsetEnable, Offset}, 32'h200);
            check("bp_pc", 32'(CounterValue), 32'h0300);
            step();
        end
        ready_mode = 1;
        step();
        check("bp_hs", {OutValid, OffsetEnable, LoadEnable}, 32'b100);
        check("bp_hs_pc", 32'(CounterValue), 32'h0300);
        step();
        check("bp_addr", 32'(InstrAddress), 32'h0301);

        // Fetch timeout
        lat_cfg = -1;
        do_reset(16'h0400);
        step();
        for (int i = 1; i < 15; i++) begin
            check("to_wait", {InstrReq, Halted, FetchError}, 32'b100);
            step();
        end
        check("to_last", {InstrReq, Halted, FetchError}, 32'b100);
        step();
        check("to_halt", {InstrReq, Halted, FetchError}, 32'b011);
        check("to_pc", 32'(CounterValue), 32'h0400);
        nReset = 1'b0;
        step();
        nReset = 1'b1;
        check("to_clear", {InstrReq, Halted, FetchError, OffsetEnable},
              32'b0001);
        lat_cfg = 0;

        mem[16'h0500] = 16'hD000;
        do_reset(16'h0500);
        step();
        step();
        check("halt", {Halted, OutValid}, 32'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_hold", {Halted, OutValid, InstrReq}, 32'b100);
            check("halt_pc", 32'(CounterValue), 32'h0500);
        end

        mem[16'h0600] = 16'h2222;
        ready_mode = 0;
        do_reset(16'h0600);
        step();
        step();
        check("mid_disp", 32'(OutValid), 32'd1);
        nReset = 1'b0;
        step();
        check("mid_rst", {OutValid, InstrReq}, 32'b00);
        nReset = 1'b1;

        // Random program, latencies, back-pressure and flags
        mem.delete();
        lat_rand   = 1'b1;
        lat_cfg    = 1;
        ready_mode = 2;
        flag_rand  = 1'b1;
        do_reset(16'($urandom));
        mon_en = 1'b1;
        repeat (3000) step();
        mon_en = 1'b0;
        check("progress", 32'(hs_count > 200), 32'd1);
        check("no_halt", {Halted, FetchError}, 32'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
